cs_address_sequencer: RTL and testbench

Microsequencer next-address controller for the control store. It is the consumer end of the control-store address incrementer path. It drives the control-store address, which is also the incrementer's input, and issues a read request. On acknowledge it receives the incremented address (CSAI) back and selects the next microinstruction address: sequential, jump, conditional branch, call or return. A small return-address stack supports microsubroutines.

---
 rtl/cs_sequencer_pkg.sv | 30 +++
 rtl/cs_return_stack.sv | 40 ++++
 rtl/cs_address_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cs_address_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_sequencer_pkg.sv
// Shared encodings for the control-store microsequencer: sequencing ops,
// sequencer states and field widths.
package cs_sequencer_pkg;

    localparam int NEXTOP_WIDTH = 3;
    localparam int COND_WIDTH   = 4;

    typedef enum logic [NEXTOP_WIDTH-1:0] {
        OP_NEXT = 3'd0,
        OP_JUMP = 3'd1,
        OP_BRT  = 3'd2,
        OP_BRF  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HALT = 3'd6
    } next_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SELECT = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    function automatic logic cond_flag(input logic [COND_WIDTH-1:0] cond,
                                       input logic [1:0]            sel);
        return cond[sel];
    endfunction

endpackage

// File: rtl/cs_return_stack.sv
// Return-address LIFO for microsubroutine calls; top entry is readable
// combinationally so the sequencer can resolve RET in its SELECT cycle.
module cs_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      ptr;
    logic [PW-1:0]    top_idx;

    assign top_idx  = ptr[PW-1:0] - 1'b1;
    assign top_data = mem[top_idx];
    assign full     = (ptr == (PW+1)'(DEPTH));
    assign empty    = (ptr == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
        end else if (push && !full) begin
            mem[ptr[PW-1:0]] <= push_data;
            ptr              <= ptr + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
        end
    end

endmodule

// File: rtl/cs_address_sequencer.sv
// Next-address controller for the control store. Build option
// CS_ADDRESS_SEQUENCER_RETURN_STACK_EN enables the CALL/RET return stack.
module cs_address_sequencer
    import cs_sequencer_pkg::*;
#(
    parameter int CSAI_DATAWIDTH = 11,
    parameter int RESET_VECTOR   = 0,
    parameter int STACK_DEPTH    = 4
) (
    input  logic                      CS_ADDRESS_SEQUENCER_CLOCK_50,
    input  logic                      CS_ADDRESS_SEQUENCER_RESET_InHigh,
    input  logic                      CS_ADDRESS_SEQUENCER_Start_In,
    input  logic                      CS_ADDRESS_SEQUENCER_ACK,
    input  logic [CSAI_DATAWIDTH-1:0] CS_ADDRESS_SEQUENCER_CSAI_InBus,
    input  logic [NEXTOP_WIDTH-1:0]   CS_ADDRESS_SEQUENCER_NextOp_InBus,
    input  logic [CSAI_DATAWIDTH-1:0] CS_ADDRESS_SEQUENCER_Target_InBus,
    input  logic [COND_WIDTH-1:0]     CS_ADDRESS_SEQUENCER_Cond_InBus,
    input  logic [1:0]                CS_ADDRESS_SEQUENCER_CondSel_InBus,
    output logic [CSAI_DATAWIDTH-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
    output logic                      CS_ADDRESS_SEQUENCER_REQ_Out,
    output logic                      CS_ADDRESS_SEQUENCER_Busy_Out,
    output logic                      CS_ADDRESS_SEQUENCER_Halted_Out,
    output logic                      CS_ADDRESS_SEQUENCER_StackErr_Out
);

    localparam logic [CSAI_DATAWIDTH-1:0] RESET_ADDR = CSAI_DATAWIDTH'(RESET_VECTOR);

    seq_state_t                state_q;
    logic [CSAI_DATAWIDTH-1:0] addr_q;
    logic                      req_q, busy_q, halted_q, err_q;

    logic [CSAI_DATAWIDTH-1:0] next_addr;
    logic                      sel_halt, sel_err, flag;
    next_op_t                  op;

    assign op   = next_op_t'(CS_ADDRESS_SEQUENCER_NextOp_InBus);
    assign flag = cond_flag(CS_ADDRESS_SEQUENCER_Cond_InBus, CS_ADDRESS_SEQUENCER_CondSel_InBus);

`ifdef CS_ADDRESS_SEQUENCER_RETURN_STACK_EN
    logic                      stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    logic [CSAI_DATAWIDTH-1:0] stk_top;

    // Stack moves only on SELECT exit; Start from HALTED discards any leftover frames.
    assign stk_push  = (state_q == ST_SELECT) && (op == OP_CALL) && !stk_full;
    assign stk_pop   = (state_q == ST_SELECT) && (op == OP_RET) && !stk_empty;
    assign stk_clear = (state_q == ST_HALTED) && CS_ADDRESS_SEQUENCER_Start_In;

    cs_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (CSAI_DATAWIDTH)
    ) u_return_stack (
        .clk       (CS_ADDRESS_SEQUENCER_CLOCK_50),
        .rst       (CS_ADDRESS_SEQUENCER_RESET_InHigh),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (CS_ADDRESS_SEQUENCER_CSAI_InBus),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`endif

    always_comb begin
        next_addr = CS_ADDRESS_SEQUENCER_CSAI_InBus;
        sel_halt  = 1'b0;
        sel_err   = 1'b0;
        case (op)
            OP_JUMP: next_addr = CS_ADDRESS_SEQUENCER_Target_InBus;
            OP_BRT:  next_addr = flag ? CS_ADDRESS_SEQUENCER_Target_InBus : CS_ADDRESS_SEQUENCER_CSAI_InBus;
            OP_BRF:  next_addr = flag ? CS_ADDRESS_SEQUENCER_CSAI_InBus : CS_ADDRESS_SEQUENCER_Target_InBus;
`ifdef CS_ADDRESS_SEQUENCER_RETURN_STACK_EN
            OP_CALL: begin
                if (stk_full) begin
                    next_addr = addr_q;
                    sel_halt  = 1'b1;
                    sel_err   = 1'b1;
                end else begin
                    next_addr = CS_ADDRESS_SEQUENCER_Target_InBus;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    next_addr = addr_q;
                    sel_halt  = 1'b1;
                    sel_err   = 1'b1;
                end else begin
                    next_addr = stk_top;
                end
            end
`else
            OP_CALL: next_addr = CS_ADDRESS_SEQUENCER_Target_InBus;
            OP_RET:  next_addr = CS_ADDRESS_SEQUENCER_CSAI_InBus;
`endif
            OP_HALT: begin
                next_addr = addr_q;
                sel_halt  = 1'b1;
            end
            default: next_addr = CS_ADDRESS_SEQUENCER_CSAI_InBus;
        endcase
    end

    always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
        if (CS_ADDRESS_SEQUENCER_RESET_InHigh) begin
            state_q  <= ST_IDLE;
            addr_q   <= RESET_ADDR;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CS_ADDRESS_SEQUENCER_Start_In) begin
                        state_q <= ST_FETCH;
                        addr_q  <= RESET_ADDR;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (CS_ADDRESS_SEQUENCER_ACK) begin
                        state_q <= ST_SELECT;
                        req_q   <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    addr_q <= next_addr;
                    if (sel_halt) begin
                        state_q  <= ST_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        err_q    <= err_q | sel_err;
                    end else begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (CS_ADDRESS_SEQUENCER_Start_In) begin
                        state_q  <= ST_FETCH;
                        addr_q   <= RESET_ADDR;
                        req_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = addr_q;
    assign CS_ADDRESS_SEQUENCER_REQ_Out          = req_q;
    assign CS_ADDRESS_SEQUENCER_Busy_Out         = busy_q;
    assign CS_ADDRESS_SEQUENCER_Halted_Out       = halted_q;
`ifdef CS_ADDRESS_SEQUENCER_RETURN_STACK_EN
    assign CS_ADDRESS_SEQUENCER_StackErr_Out     = err_q;
`else
    assign CS_ADDRESS_SEQUENCER_StackErr_Out     = 1'b0;
`endif

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Scoreboard bench for cs_address_sequencer: the driver plays control store and
// reference model, the monitor checks every FETCH entry and halt against the queue.
module tb_cs_address_sequencer;

    localparam int W     = 11;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << W) - 1;
    localparam int RV    = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ack;
    logic [W-1:0] csai;
    logic [2:0]   nextop;
    logic [W-1:0] target;
    logic [3:0]   cond;
    logic [1:0]   condsel;
    logic [W-1:0] csaddr;
    logic         req, busy, halted, stackerr;

    cs_address_sequencer #(
        .CSAI_DATAWIDTH (W),
        .RESET_VECTOR   (RV),
        .STACK_DEPTH    (DEPTH)
    ) dut (
        .CS_ADDRESS_SEQUENCER_CLOCK_50        (clk),
        .CS_ADDRESS_SEQUENCER_RESET_InHigh    (rst),
        .CS_ADDRESS_SEQUENCER_Start_In        (start),
        .CS_ADDRESS_SEQUENCER_ACK             (ack),
        .CS_ADDRESS_SEQUENCER_CSAI_InBus      (csai),
        .CS_ADDRESS_SEQUENCER_NextOp_InBus    (nextop),
        .CS_ADDRESS_SEQUENCER_Target_InBus    (target),
        .CS_ADDRESS_SEQUENCER_Cond_InBus      (cond),
        .CS_ADDRESS_SEQUENCER_CondSel_InBus   (condsel),
        .CS_ADDRESS_SEQUENCER_CSAddress_OutBus(csaddr),
        .CS_ADDRESS_SEQUENCER_REQ_Out         (req),
        .CS_ADDRESS_SEQUENCER_Busy_Out        (busy),
        .CS_ADDRESS_SEQUENCER_Halted_Out      (halted),
        .CS_ADDRESS_SEQUENCER_StackErr_Out    (stackerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit halted;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state: current address, return stack as a plain queue.
    int   m_addr;
    int   m_stack[$];
    bit   m_halted;
    bit   m_err;

    task automatic check(input string name, input int act, input int req_v);
        compared++;
        if (act != req_v) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Monitor: every FETCH entry or halt entry consumes one expectation;
    // while fetching, the address must hold at the expected value.
    bit prev_req = 1'b0, prev_halted = 1'b0;
    int cur_addr = RV;
    always @(negedge clk) begin
        exp_t e;
        if ((req && !prev_req) || (halted && !prev_halted)) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: addr 0x%0h req %0d halted %0d, expected no event", csaddr, req, halted);
            end else begin
                e = exp_q.pop_front();
                cur_addr = e.addr;
                check("addr", int'(csaddr), e.addr);
                check("halted", int'(halted), int'(e.halted));
                check("stackerr", int'(stackerr), int'(e.err));
                check("busy", int'(busy), int'(!e.halted));
                check("req", int'(req), int'(!e.halted));
            end
        end else if (req) begin
            check("addr_stable", int'(csaddr), cur_addr);
        end
        prev_req    = req;
        prev_halted = halted;
    end

    task automatic push_exp();
        exp_t e;
        e.addr = m_addr; e.halted = m_halted; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic start_seq();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        m_addr   = RV;
        m_stack  = {};
        m_halted = 1'b0;
        m_err    = 1'b0;
        push_exp();
    endtask

    // Model of one SELECT decision, from the op table.
    task automatic model_select(input int op, input int tgt, input int cnd, input int sel, input int c);
        bit f;
        f = cnd[sel];
        case (op)
            1: m_addr = tgt;
            2: m_addr = f ? tgt : c;
            3: m_addr = f ? c : tgt;
`ifdef CS_ADDRESS_SEQUENCER_RETURN_STACK_EN
            4: if (m_stack.size() == DEPTH) begin m_halted = 1; m_err = 1; end
               else begin m_stack.push_back(c); m_addr = tgt; end
            5: if (m_stack.size() == 0) begin m_halted = 1; m_err = 1; end
               else m_addr = m_stack.pop_back();
`else
            4: m_addr = tgt;
            5: m_addr = c;
`endif
            6: m_halted = 1;
            default: m_addr = c;
        endcase
    endtask

    // One microinstruction: called just after the edge that entered FETCH.
    task automatic do_instr(input int op, input int tgt, input int cnd, input int sel, input int waits);
        int c;
        check("req_in_fetch", int'(req), 1);
        csai = W'($urandom); nextop = 3'($urandom); target = W'($urandom);
        repeat (waits) begin
            ack = 1'b0;
            @(posedge clk); #1;
        end
        ack = 1'b1;
        @(posedge clk); #1;
        check("req_low_in_select", int'(req), 0);
        ack     = 1'($urandom);
        c       = (m_addr + 1) & MASK;
        csai    = W'(c);
        nextop  = 3'(op);
        target  = W'(tgt);
        cond    = 4'(cnd);
        condsel = 2'(sel);
        model_select(op, tgt, cnd, sel, c);
        push_exp();
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; ack = 1'b1;
        csai = '0; nextop = '0; target = '0; cond = '0; condsel = '0;
        m_stack = {}; m_addr = RV; m_halted = 0; m_err = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; ack = 1'b0;
        @(negedge clk);
        check("reset_addr", int'(csaddr), RV);
        check("reset_req", int'(req), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_halted", int'(halted), 0);
        check("reset_stackerr", int'(stackerr), 0);
        @(posedge clk); #1;

        // Sequential stepping, then jump with delayed ACK.
        start_seq();
        repeat (3) do_instr(0, 0, 0, 0, 0);
        do_instr(1, 'h005, 0, 0, 0);
        do_instr(1, 'h100, 0, 0, 3);

        // Branches on flag 2, taken and not taken, both senses.
        do_instr(2, 'h040, 'b0100, 2, 0);
        do_instr(2, 'h050, 'b0000, 2, 1);
        do_instr(3, 'h060, 'b0100, 2, 0);
        do_instr(3, 'h070, 'b0000, 2, 0);

        // Call and return, then overflow the stack.
        do_instr(1, 'h010, 0, 0, 0);
        do_instr(4, 'h200, 0, 0, 0);
        do_instr(5, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (!m_halted) do_instr(4, 'h300 + i * 16, 0, 0, i % 2);
        end
        if (m_halted) start_seq();

        // Return with an empty stack.
        do_instr(5, 0, 0, 0, 0);
        if (m_halted) start_seq();

        // Reset during FETCH with ACK, then wrap from the top address.
        ack = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; rst = 1'b0;
        m_stack = {};
        @(negedge clk);
        check("midreset_req", int'(req), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_addr", int'(csaddr), RV);
        check("midreset_halted", int'(halted), 0);
        @(posedge clk); #1;
        start_seq();
        do_instr(1, 'h7FF, 0, 0, 0);
        do_instr(0, 0, 0, 0, 0);
        do_instr(6, 0, 0, 0, 0);
        start_seq();

        // Randomized microprograms.
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op > 7) op = op - 8;
            if (op == 6 && $urandom_range(0, 3) != 0) op = 0;
            do_instr(op, int'($urandom_range(0, MASK)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if (m_halted) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                start_seq();
            end
        end

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
